opponent_ctrl_sched: RTL and testbench

- Sits between the opponent command sources and the physics module. The sources are the computer-player decision block and the player-2 keyboard decoder.
- Selects the active source and samples its commands once per video frame. AI commands pass through a difficulty-dependent reaction-delay buffer.
- Shapes jump/smash into frame-counted pulses with a jump cooldown, then drives the opponent's registered move/jump/smash controls.

---
 rtl/game_ctrl_pkg.sv | 33 +++
 rtl/opponent_ctrl_sched_if.sv | 36 +++
 rtl/reaction_delay_line.sv | 64 ++++++
 rtl/opponent_ctrl_sched.sv | 170 +++++++++++++++++
 tb/tb_opponent_ctrl_sched.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_ctrl_pkg.sv
// rtl/game_ctrl_pkg.sv - shared command-vector indices, FSM encodings and difficulty table
package game_ctrl_pkg;

  // Bit positions inside a 4-bit command vector {L,R,J,S}
  localparam int CMD_L = 3;
  localparam int CMD_R = 2;
  localparam int CMD_J = 1;
  localparam int CMD_S = 0;

  typedef logic [3:0] cmd_t;

  // Top-level scheduler states
  localparam logic [0:0] TOP_FREEZE = 1'b0;
  localparam logic [0:0] TOP_RUN    = 1'b1;

  // Jump shaping states
  localparam logic [1:0] JMP_READY = 2'd0;
  localparam logic [1:0] JMP_HOLD  = 2'd1;
  localparam logic [1:0] JMP_COOL  = 2'd2;

  // AI reaction delay in frames for each difficulty setting
  function automatic logic [2:0] diff_to_delay(input logic [1:0] diff);
    logic [2:0] d;
    case (diff)
      2'd0:    d = 3'd0;
      2'd1:    d = 3'd2;
      2'd2:    d = 3'd4;
      default: d = 3'd7;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/opponent_ctrl_sched_if.sv
// rtl/opponent_ctrl_sched_if.sv - command sources in, opponent controls out
interface opponent_ctrl_sched_if;
  logic       frame_tick;
  logic       game_run;
  logic       mode_ai;
  logic [1:0] difficulty;
  logic       ai_left;
  logic       ai_right;
  logic       ai_jump;
  logic       ai_smash;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic       key_smash;
  logic       op_move_left;
  logic       op_move_right;
  logic       op_jump;
  logic       op_smash;
  logic       busy_jump;

  // Game logic side: drives sources, observes controls
  modport master (
    output frame_tick, game_run, mode_ai, difficulty,
    output ai_left, ai_right, ai_jump, ai_smash,
    output key_left, key_right, key_jump, key_smash,
    input  op_move_left, op_move_right, op_jump, op_smash, busy_jump
  );

  // Scheduler side
  modport slave (
    input  frame_tick, game_run, mode_ai, difficulty,
    input  ai_left, ai_right, ai_jump, ai_smash,
    input  key_left, key_right, key_jump, key_smash,
    output op_move_left, op_move_right, op_jump, op_smash, busy_jump
  );
endinterface

// File: rtl/reaction_delay_line.sv
// rtl/reaction_delay_line.sv - circular command delay buffer with fill tracking and bypass tap
module reaction_delay_line #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_i,
  input  logic                     flush_i,
  input  logic [$clog2(DEPTH)-1:0] delay_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] fill_q;
  logic [AW-1:0] fill_d;
  logic [AW-1:0] eff_fill;
  logic [AW-1:0] rd_idx;

  // A flush discards history immediately; the entry written alongside it survives
  assign eff_fill = flush_i ? '0 : fill_q;
  assign rd_idx   = wptr_q - delay_i;

  // Read tap: zero delay bypasses the array, too little history reads as a bubble
  always_comb begin
    dout_o = '0;
    if (delay_i == '0) begin
      dout_o = din_i;
    end else if (eff_fill >= delay_i) begin
      dout_o = mem_q[rd_idx];
    end
  end

  // Saturating count of valid entries written before the current one
  always_comb begin
    fill_d = fill_q;
    if (wr_i) begin
      fill_d = (eff_fill == FILL_MAX) ? FILL_MAX : eff_fill + AW'(1);
    end else if (flush_i) begin
      fill_d = '0;
    end
  end

  // Storage, write pointer and fill register
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      fill_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fill_q <= fill_d;
      if (wr_i) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + AW'(1);
      end
    end
  end
endmodule

// File: rtl/opponent_ctrl_sched.sv
// rtl/opponent_ctrl_sched.sv - frame-paced opponent command scheduler with jump/smash shaping
module opponent_ctrl_sched #(
  parameter int DEPTH      = 8,
  parameter int JUMP_HOLD  = 6,
  parameter int JUMP_COOL  = 20,
  parameter int SMASH_HOLD = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  opponent_ctrl_sched_if.slave bus
);
  import game_ctrl_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int JW = $clog2(((JUMP_HOLD > JUMP_COOL) ? JUMP_HOLD : JUMP_COOL) + 1);
  localparam int SW = $clog2(SMASH_HOLD + 1);

  logic [0:0]    top_q, top_d;
  logic          mode_prev_q, mode_prev_d;
  logic [1:0]    diff_prev_q, diff_prev_d;
  logic [1:0]    jst_q, jst_d;
  logic [JW-1:0] jcnt_q, jcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          left_q, left_d;
  logic          right_q, right_d;
  logic          jump_q, jump_d;
  logic          smash_q, smash_d;

  logic          start_tick;
  logic          run_tick;
  logic          mode_sw;
  logic          diff_chg;
  logic          conflict;
  logic [AW-1:0] delay;
  cmd_t          ai_vec;
  cmd_t          key_vec;
  cmd_t          dl_out;
  cmd_t          sel_vec;

  assign start_tick = bus.frame_tick & bus.game_run & (top_q == TOP_FREEZE);
  assign run_tick   = bus.frame_tick & bus.game_run & (top_q == TOP_RUN);
  assign mode_sw    = run_tick & (bus.mode_ai != mode_prev_q);
  assign diff_chg   = run_tick & (bus.difficulty != diff_prev_q);
  assign delay      = AW'(diff_to_delay(bus.difficulty));

  assign ai_vec  = {bus.ai_left, bus.ai_right, bus.ai_jump, bus.ai_smash};
  assign key_vec = {bus.key_left, bus.key_right, bus.key_jump, bus.key_smash};

  reaction_delay_line #(
    .DEPTH (DEPTH),
    .W     (4)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (start_tick | run_tick),
    .flush_i (~bus.game_run | mode_sw | diff_chg),
    .delay_i (delay),
    .din_i   (ai_vec),
    .dout_o  (dl_out)
  );

  // Source selection; the tick that sees a source change drives nothing new
  assign sel_vec  = mode_sw ? '0 : (bus.mode_ai ? dl_out : key_vec);
  assign conflict = sel_vec[CMD_L] & sel_vec[CMD_R];

  // Next-state: freeze override, rally start, then per-frame shaping
  always_comb begin
    top_d       = top_q;
    mode_prev_d = mode_prev_q;
    diff_prev_d = diff_prev_q;
    jst_d       = jst_q;
    jcnt_d      = jcnt_q;
    scnt_d      = scnt_q;
    left_d      = left_q;
    right_d     = right_q;
    jump_d      = jump_q;
    smash_d     = smash_q;
    if (!bus.game_run) begin
      top_d   = TOP_FREEZE;
      jst_d   = JMP_READY;
      jcnt_d  = '0;
      scnt_d  = '0;
      left_d  = 1'b0;
      right_d = 1'b0;
      jump_d  = 1'b0;
      smash_d = 1'b0;
    end else if (start_tick) begin
      top_d       = TOP_RUN;
      mode_prev_d = bus.mode_ai;
      diff_prev_d = bus.difficulty;
    end else if (run_tick) begin
      mode_prev_d = bus.mode_ai;
      diff_prev_d = bus.difficulty;
      left_d      = sel_vec[CMD_L] & ~conflict;
      right_d     = sel_vec[CMD_R] & ~conflict;
      case (jst_q)
        JMP_READY: begin
          if (sel_vec[CMD_J]) begin
            jst_d  = JMP_HOLD;
            jcnt_d = JW'(JUMP_HOLD - 1);
            jump_d = 1'b1;
          end
        end
        JMP_HOLD: begin
          if (jcnt_q == '0) begin
            jst_d  = JMP_COOL;
            jcnt_d = JW'(JUMP_COOL - 1);
            jump_d = 1'b0;
          end else begin
            jcnt_d = jcnt_q - JW'(1);
          end
        end
        JMP_COOL: begin
          if (jcnt_q == '0) begin
            jst_d = JMP_READY;
          end else begin
            jcnt_d = jcnt_q - JW'(1);
          end
        end
        default: begin
          jst_d  = JMP_READY;
          jcnt_d = '0;
          jump_d = 1'b0;
        end
      endcase
      if (scnt_q != '0) begin
        smash_d = 1'b1;
        scnt_d  = scnt_q - SW'(1);
      end else if (sel_vec[CMD_S]) begin
        smash_d = 1'b1;
        scnt_d  = SW'(SMASH_HOLD - 1);
      end else begin
        smash_d = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q       <= TOP_FREEZE;
      mode_prev_q <= 1'b0;
      diff_prev_q <= '0;
      jst_q       <= JMP_READY;
      jcnt_q      <= '0;
      scnt_q      <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      jump_q      <= 1'b0;
      smash_q     <= 1'b0;
    end else begin
      top_q       <= top_d;
      mode_prev_q <= mode_prev_d;
      diff_prev_q <= diff_prev_d;
      jst_q       <= jst_d;
      jcnt_q      <= jcnt_d;
      scnt_q      <= scnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      jump_q      <= jump_d;
      smash_q     <= smash_d;
    end
  end

  assign bus.op_move_left  = left_q;
  assign bus.op_move_right = right_q;
  assign bus.op_jump       = jump_q;
  assign bus.op_smash      = smash_q;
  assign bus.busy_jump     = (jst_q != JMP_READY);
endmodule

// File: tb/tb_opponent_ctrl_sched.sv
// tb/tb_opponent_ctrl_sched.sv - randomized self-checking bench against a frame-level model
module tb_opponent_ctrl_sched;
  localparam int DEPTH      = 8;
  localparam int JUMP_HOLD  = 6;
  localparam int JUMP_COOL  = 20;
  localparam int SMASH_HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  opponent_ctrl_sched_if bus();

  opponent_ctrl_sched #(
    .DEPTH      (DEPTH),
    .JUMP_HOLD  (JUMP_HOLD),
    .JUMP_COOL  (JUMP_COOL),
    .SMASH_HOLD (SMASH_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: rally flag, last sampled source/difficulty, AI history since last flush,
  // frames since current jump started (-1 idle), remaining smash frames
  bit       m_run;
  bit       m_mode;
  bit [1:0] m_diff;
  bit [3:0] m_hist[$];
  int       m_jage;
  int       m_sleft;
  bit [4:0] exp_v;   // {L,R,J,S,busy}
  bit [4:0] obs_v;

  function automatic int dly(input bit [1:0] d);
    case (d)
      2'd0:    return 0;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 7;
    endcase
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_hist.delete();
    m_jage  = -1;
    m_sleft = 0;
    exp_v   = '0;
  endtask

  task automatic model_tick(input bit gr, input bit mai, input bit [1:0] dif,
                            input bit [3:0] ai, input bit [3:0] key);
    bit [3:0] v;
    bit [3:0] tap;
    bit       sw;
    bit       dc;
    int       d;
    if (!gr) begin
      model_reset();
      return;
    end
    if (!m_run) begin
      m_run  = 1'b1;
      m_mode = mai;
      m_diff = dif;
      m_hist.delete();
      m_hist.push_back(ai);
      exp_v  = '0;
      return;
    end
    sw     = (mai != m_mode);
    dc     = (dif != m_diff);
    m_mode = mai;
    m_diff = dif;
    if (sw || dc) m_hist.delete();
    m_hist.push_back(ai);
    if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
    d = dly(dif);
    if (d == 0) tap = ai;
    else if (m_hist.size() > d) tap = m_hist[m_hist.size() - 1 - d];
    else tap = '0;
    v = sw ? 4'b0 : (mai ? tap : key);
    exp_v[4] = v[3] && !v[2];
    exp_v[3] = v[2] && !v[3];
    if (m_jage < 0) begin
      if (v[1]) m_jage = 0;
    end else begin
      m_jage++;
      if (m_jage == JUMP_HOLD + JUMP_COOL) m_jage = -1;
    end
    exp_v[2] = (m_jage >= 0) && (m_jage < JUMP_HOLD);
    exp_v[0] = (m_jage >= 0);
    if (m_sleft == 0 && v[0]) m_sleft = SMASH_HOLD;
    exp_v[1] = (m_sleft > 0);
    if (m_sleft > 0) m_sleft--;
  endtask

  task automatic sample();
    obs_v = {bus.op_move_left, bus.op_move_right, bus.op_jump, bus.op_smash, bus.busy_jump};
  endtask

  // One video frame: inputs set, one tick cycle, outputs sampled, one idle cycle
  task automatic frame(input bit gr, input bit mai, input bit [1:0] dif,
                       input bit [3:0] ai, input bit [3:0] key);
    @(negedge clk);
    bus.game_run   = gr;
    bus.mode_ai    = mai;
    bus.difficulty = dif;
    {bus.ai_left, bus.ai_right, bus.ai_jump, bus.ai_smash}     = ai;
    {bus.key_left, bus.key_right, bus.key_jump, bus.key_smash} = key;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    model_tick(gr, mai, dif, ai, key);
    sample();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sample();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    pulse_reset();
    n_cmp++;
    if (obs_v !== 5'b0) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", obs_v, 5'b0);
    end
    frame(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111);
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_freeze: got %b want %b", obs_v, exp_v);
    end
  endtask

  task automatic test_ai_bypass();
    frame(1'b1, 1'b1, 2'd0, 4'b0100, 4'b0000);
    n_cmp++;
    if (obs_v !== 5'b00000 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_first_tick: got %b want %b", obs_v, 5'b00000);
    end
    frame(1'b1, 1'b1, 2'd0, 4'b0100, 4'b0000);
    n_cmp++;
    if (obs_v !== 5'b01000 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL bypass_second_tick: got %b want %b", obs_v, 5'b01000);
    end
  endtask

  task automatic test_delay();
    frame(1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000);
    frame(1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000);
    for (int k = 0; k < 12; k++) begin
      frame(1'b1, 1'b1, 2'd3, (k == 0) ? 4'b1000 : 4'b0000, 4'b0000);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[4] !== (k == 7)) begin
        n_fail++;
        $display("FAIL delay7 tick N+%0d: got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_jump_keyboard();
    frame(1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000);
    n_cmp++;
    if (obs_v !== 5'b0 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL jump_switch_tick: got %b want %b", obs_v, 5'b0);
    end
    for (int k = 0; k < 60; k++) begin
      bit wj;
      bit wb;
      frame(1'b1, 1'b0, 2'd3, 4'b0000, 4'b0010);
      wj = (k % 27) < JUMP_HOLD;
      wb = (k % 27) < (JUMP_HOLD + JUMP_COOL);
      n_cmp++;
      if (obs_v !== exp_v || obs_v[2] !== wj || obs_v[0] !== wb) begin
        n_fail++;
        $display("FAIL jump_held tick %0d: got %b want %b (jump %b busy %b)",
                 k, obs_v, exp_v, wj, wb);
      end
    end
  endtask

  task automatic test_conflict_smash();
    frame(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
    frame(1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000);
    frame(1'b1, 1'b1, 2'd0, 4'b1100, 4'b0000);
    n_cmp++;
    if (obs_v[4:3] !== 2'b00 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL conflict: got %b want %b", obs_v, exp_v);
    end
    for (int k = 1; k <= 14; k++) begin
      frame(1'b1, 1'b1, 2'd0, (k <= 10) ? 4'b0001 : 4'b0000, 4'b0000);
      n_cmp++;
      if (obs_v !== exp_v || (k <= 10 && obs_v[1] !== 1'b1)) begin
        n_fail++;
        $display("FAIL smash tick %0d: got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_switch();
    frame(1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000);
    frame(1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000);
    for (int k = 0; k < 6; k++) begin
      frame(1'b1, 1'b1, 2'd3, 4'($urandom) & 4'b1100, 4'b0000);
    end
    for (int k = 0; k < 11; k++) begin
      frame(1'b1, 1'b0, 2'd3, 4'($urandom), 4'b0000);
      n_cmp++;
      if (obs_v !== 5'b0 || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL switch tick %0d: got %b want %b", k, obs_v, 5'b0);
      end
    end
  endtask

  task automatic test_freeze_jump();
    frame(1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010);
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
    frame(1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000);
    n_cmp++;
    if (obs_v !== 5'b0) begin
      n_fail++;
      $display("FAIL freeze_mid_jump: got %b want %b", obs_v, 5'b0);
    end
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010);
    n_cmp++;
    if (obs_v !== 5'b0 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL restart_tick: got %b want %b", obs_v, 5'b0);
    end
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010);
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
    pulse_reset();
    n_cmp++;
    if (obs_v !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_jump: got %b want %b", obs_v, 5'b0);
    end
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000);
    frame(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0010);
    n_cmp++;
    if (obs_v !== 5'b00101 || obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL jump_after_reset: got %b want %b", obs_v, 5'b00101);
    end
  endtask

  task automatic test_random();
    bit       gr  = 1'b1;
    bit       mai = 1'b1;
    bit [1:0] dif = 2'd1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
        n_cmp++;
        if (obs_v !== 5'b0) begin
          n_fail++;
          $display("FAIL random_reset at %0d: got %b want %b", k, obs_v, 5'b0);
        end
      end
      gr = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 19) == 0) mai = ~mai;
      if ($urandom_range(0, 14) == 0) dif = 2'($urandom);
      frame(gr, mai, dif, 4'($urandom), 4'($urandom));
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random frame %0d: got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.game_run   = 1'b0;
    bus.mode_ai    = 1'b0;
    bus.difficulty = 2'd0;
    {bus.ai_left, bus.ai_right, bus.ai_jump, bus.ai_smash}     = 4'b0;
    {bus.key_left, bus.key_right, bus.key_jump, bus.key_smash} = 4'b0;
    model_reset();
    test_reset();
    test_ai_bypass();
    test_delay();
    test_jump_keyboard();
    test_conflict_smash();
    test_switch();
    test_freeze_jump();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
